adc_if_mc: RTL and testbench
============================

# adc_if_mc

Parametrised multi-channel successor to the dual-channel parallel ADC interface. It sequences the ADC power-up and output-enable pins, captures NCH parallel sample buses with their over-range flags, and converts each sample to sign-extended two's complement. Optionally it averages 2^LOG2_AVG samples per output and keeps per-channel over-range event counters. It sits between the ADC pins and the DSP (DDC) front end.

## Interface
- DATA_W, 12: ADC sample width.
- NCH, 2: channel count.
- OUT_W, 16: output sample width; must be ≥ DATA_W.
- LOG2_AVG, 0: log2 of the averaging block length; 0 means no averaging.
- WAKE_CYC, 1024: cycles from PDWN release to OEB release.
- PIPE_CYC, 8: cycles from OEB release to RUN (ADC pipeline flush).
- OTR_CNT_W, 16: width of each over-range counter.
- DCS_EN, 1: constant value driven on dcs.

Ports:
- clk, in, 1: sample clock; the only clock.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: interface enable.
- ch_en, in, NCH: per-channel enable. Latched on leaving OFF.
- fmt_twos, in, 1: ADC output format select. Latched on leaving OFF; drives dfs.
- adc_data, in, NCH*DATA_W: packed sample buses; channel 0 in the LSBs.
- adc_otr, in, NCH: over-range flags.
- adc_oeb, out, NCH: output enable, active-low.
- adc_pdwn, out, NCH: power-down, active-high.
- dcs, out, 1: duty-cycle stabiliser enable.
- dfs, out, 1: data format select (1 = two's complement).
- otr_clr, in, 1: synchronous clear of all over-range counters.
- out_data, out, NCH*OUT_W: packed converted samples.
- out_valid, out, 1: one-cycle strobe marking out_data valid for all channels.
- otr_cnt, out, NCH*OTR_CNT_W: packed saturating over-range counters.
- running, out, 1: high while the FSM is in RUN.

## Operation
- Reset values: adc_pdwn all 1; adc_oeb all 1; dcs = DCS_EN; dfs 0; out_data 0; out_valid 0; otr_cnt 0; running 0; FSM in OFF.
- FSM states are OFF, WAKE, FLUSH and RUN. All outputs are registered.
  - OFF: pdwn and oeb all 1. When en = 1, latch ch_en and fmt_twos, then go to WAKE.
  - WAKE: adc_pdwn = ~ch_en_q. Stay WAKE_CYC cycles, then go to FLUSH.
  - FLUSH: adc_oeb = ~ch_en_q as well. Stay PIPE_CYC cycles, then go to RUN.
  - RUN: running = 1. Samples flow through the pipeline.
- en = 0 in any state forces OFF at the next edge:
  - pdwn and oeb return to 1 and out_valid goes to 0.
  - Pipeline and accumulators are cleared and any partial average is discarded.
  - otr_cnt is kept.
- Changes to ch_en or fmt_twos outside OFF are ignored.
- Per-channel pipeline (active only in RUN):
  - S1 registers adc_data and adc_otr.
  - S2 converts. If fmt_q = 0, invert the MSB (offset binary to two's complement). If OTR is set, clamp to +max (2^(DATA_W-1)-1) when the sign is 0, otherwise to -2^(DATA_W-1).
  - S3 accumulates in DATA_W+LOG2_AVG bits. After 2^LOG2_AVG samples, output sum >>> LOG2_AVG (arithmetic shift), sign-extend to OUT_W and pulse out_valid.
- A disabled channel outputs 0, and its counter does not count.
- Over-range counter: increments on each S1 sample with OTR = 1 while in RUN, and saturates at 2^OTR_CNT_W-1.
  - otr_clr alone sets the counter to 0.
  - otr_clr together with an OTR event in the same cycle sets the counter to 1.

## Timing
- en sampled high at edge 0:
  - pdwn falls after edge 0.
  - oeb falls after edge WAKE_CYC.
  - running rises after edge WAKE_CYC+PIPE_CYC.
- Latency with LOG2_AVG = 0: a pin sample at edge n appears on out_data/out_valid after edge n+3. out_valid is high every RUN cycle.
- With LOG2_AVG > 0: out_valid pulses once per 2^LOG2_AVG cycles, three edges after the last sample of the block.
- Asynchronous reset mid-operation: all outputs go immediately to their reset values, independent of clk.

## Structure
- Shared package adc_pkg holds:
  - FSM state encodings (OFF=0, WAKE=1, FLUSH=2, RUN=3).
  - Format constants FMT_OFFSET=0 and FMT_TWOS=1.
- Sub-module adc_chan (S1–S3 plus the OTR counter) is instantiated NCH times by generate.
- The top level holds the FSM, the wake/flush counter and config latching.

## Test plan
- Startup with WAKE_CYC=4, PIPE_CYC=3, en raised: pdwn falls after edge 0, oeb after edge 4, running after edge 7, first out_valid after edge 10.
- Offset-binary format (dfs=0), DATA_W=12, OUT_W=16: 12'h800 → 16'h0000; 12'hFFF → 16'h07FF; 12'h000 → 16'hF800.
- Two's-complement format: 12'h800 → 16'hF800 and 12'h7FF → 16'h07FF.
- OTR=1 with data 12'hFFF → 16'h07FF and the counter increments. With OTR_CNT_W=4, 20 events leave the counter at 15. otr_clr in the same cycle as an event gives 1.
- LOG2_AVG=2: inputs 100, 101, 102, 103 → one output of 101, with out_valid once per 4 cycles. Inputs -1, -2, -2, -2 → -2.
- en dropped after 2 of 4 averaged samples: next edge pdwn and oeb are 1, out_valid 0, running 0. Re-enable repeats the full WAKE/FLUSH sequence and the first average uses only new samples.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel parallel ADC interface:
// sequencer state encoding and ADC output-format constants.
package adc_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_WAKE  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   localparam logic FMT_OFFSET = 1'b0;
   localparam logic FMT_TWOS   = 1'b1;

endpackage

// File: rtl/adc_chan.sv
// One ADC channel: capture (S1), format conversion with over-range clamp (S2),
// block averaging (S3) and a saturating over-range event counter.
module adc_chan
   import adc_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int OUT_W     = 16,
   parameter int LOG2_AVG  = 0,
   parameter int OTR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic                 chan_en,
   input  logic                 fmt,
   input  logic                 otr_clr,
   input  logic [DATA_W-1:0]    data,
   input  logic                 otr,
   output logic [OUT_W-1:0]     out_data,
   output logic                 out_valid,
   output logic [OTR_CNT_W-1:0] otr_cnt
);

   localparam int ACC_W = DATA_W + LOG2_AVG;
   localparam int BLK_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((1 << LOG2_AVG) - 1);

   logic [DATA_W-1:0]        s1_data;
   logic                     s1_otr;
   logic                     s1_vld;
   logic [DATA_W-1:0]        conv;
   logic signed [DATA_W-1:0] s2_data;
   logic                     s2_vld;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  sum;
   logic [BLK_W-1:0]         blk_cnt;
   logic signed [DATA_W-1:0] blk_q;
   logic                     done_q;
   logic                     evt;

   // Offset binary becomes two's complement by flipping the MSB; an over-range
   // sample is pinned to the full-scale value on the side its sign points to.
   always_comb begin
      conv = s1_data;
      if (fmt == FMT_OFFSET) conv[DATA_W-1] = ~s1_data[DATA_W-1];
      if (s1_otr) conv = conv[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
   end

   assign sum = acc_q + ACC_W'(s2_data);
   assign evt = run && chan_en && otr;

   // NOTE: registered state is always written with <=, so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data <= '0;
         s1_otr  <= 1'b0;
         s1_vld  <= 1'b0;
         s2_data <= '0;
         s2_vld  <= 1'b0;
      end else if (!run) begin
         s1_data <= '0;
         s1_otr  <= 1'b0;
         s1_vld  <= 1'b0;
         s2_data <= '0;
         s2_vld  <= 1'b0;
      end else begin
         s1_data <= data;
         s1_otr  <= otr;
         s1_vld  <= 1'b1;
         s2_data <= conv;
         s2_vld  <= s1_vld;
      end
   end

   // Leaving RUN throws away any partially accumulated block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         blk_cnt   <= '0;
         blk_q     <= '0;
         done_q    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (!run) begin
         acc_q     <= '0;
         blk_cnt   <= '0;
         blk_q     <= '0;
         done_q    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (s2_vld) begin
            if (blk_cnt == BLK_LAST) begin
               blk_q   <= sum[LOG2_AVG +: DATA_W];
               acc_q   <= '0;
               blk_cnt <= '0;
               done_q  <= 1'b1;
            end else begin
               acc_q   <= sum;
               blk_cnt <= blk_cnt + BLK_W'(1);
            end
         end
         out_valid <= done_q;
         if (done_q) out_data <= chan_en ? OUT_W'(blk_q) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         otr_cnt <= '0;
      else if (otr_clr)                   otr_cnt <= OTR_CNT_W'(evt);
      else if (evt && (otr_cnt != '1))    otr_cnt <= otr_cnt + OTR_CNT_W'(1);
   end

endmodule

// File: rtl/adc_if_mc.sv
// Multi-channel parallel ADC interface: power-up/output-enable sequencer,
// configuration latching and NCH capture/convert/average channels.
module adc_if_mc
   import adc_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int NCH       = 2,
   parameter int OUT_W     = 16,
   parameter int LOG2_AVG  = 0,
   parameter int WAKE_CYC  = 1024,
   parameter int PIPE_CYC  = 8,
   parameter int OTR_CNT_W = 16,
   parameter int DCS_EN    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [NCH-1:0]           ch_en,
   input  logic                     fmt_twos,
   input  logic [NCH*DATA_W-1:0]    adc_data,
   input  logic [NCH-1:0]           adc_otr,
   output logic [NCH-1:0]           adc_oeb,
   output logic [NCH-1:0]           adc_pdwn,
   output logic                     dcs,
   output logic                     dfs,
   input  logic                     otr_clr,
   output logic [NCH*OUT_W-1:0]     out_data,
   output logic                     out_valid,
   output logic [NCH*OTR_CNT_W-1:0] otr_cnt,
   output logic                     running
);

   localparam int CNT_MAX = (WAKE_CYC > PIPE_CYC) ? WAKE_CYC : PIPE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]   ch_en_q;
   logic [NCH-1:0]   ch_cfg;
   logic             fmt_q;
   logic             run;
   logic [NCH-1:0]   valid_vec;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_cfg  = (state_q == ST_OFF) ? ch_en : ch_en_q;
      case (state_q)
         ST_OFF: begin
            state_d = ST_WAKE;
            cnt_d   = '0;
         end
         ST_WAKE: begin
            if (cnt_q == CNT_W'(WAKE_CYC - 1)) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FLUSH: begin
            if (cnt_q == CNT_W'(PIPE_CYC - 1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_OFF;
      endcase
      if (!en) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end
   end

   assign run = (state_d == ST_RUN);

   // Pin controls are registered from the next state so they change on the
   // same edge as the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         cnt_q    <= '0;
         ch_en_q  <= '0;
         fmt_q    <= FMT_OFFSET;
         adc_pdwn <= '1;
         adc_oeb  <= '1;
         running  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_OFF && en) begin
            ch_en_q <= ch_en;
            fmt_q   <= fmt_twos;
         end
         adc_pdwn <= (state_d == ST_OFF) ? '1 : ~ch_cfg;
         adc_oeb  <= (state_d == ST_FLUSH || state_d == ST_RUN) ? ~ch_cfg : '1;
         running  <= run;
      end
   end

   assign dfs       = fmt_q;
   assign dcs       = (DCS_EN != 0);
   assign out_valid = valid_vec[0];

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      adc_chan #(
         .DATA_W    (DATA_W),
         .OUT_W     (OUT_W),
         .LOG2_AVG  (LOG2_AVG),
         .OTR_CNT_W (OTR_CNT_W)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .run       (run),
         .chan_en   (ch_en_q[i]),
         .fmt       (fmt_q),
         .otr_clr   (otr_clr),
         .data      (adc_data[i*DATA_W +: DATA_W]),
         .otr       (adc_otr[i]),
         .out_data  (out_data[i*OUT_W +: OUT_W]),
         .out_valid (valid_vec[i]),
         .otr_cnt   (otr_cnt[i*OTR_CNT_W +: OTR_CNT_W])
      );
   end

endmodule

// File: tb/tb_adc_if_mc.sv
// Randomised bench for adc_if_mc: one plain instance and one 4-sample averaging
// instance share stimulus and are compared against a sample-level reference model.
module tb_adc_if_mc;

   localparam int DW   = 12;
   localparam int NCH  = 2;
   localparam int OW   = 16;
   localparam int CW   = 4;
   localparam int WAKE = 4;
   localparam int PIPE = 3;
   localparam int CAP0 = WAKE + PIPE;   // first edge whose pin sample is captured
   localparam int CMAX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic [NCH-1:0]    ch_en = '0;
   logic              fmt_twos = 1'b0;
   logic [NCH*DW-1:0] adc_data = '0;
   logic [NCH-1:0]    adc_otr = '0;
   logic              otr_clr = 1'b0;

   logic [NCH-1:0]    oeb0, pdwn0, oeb1, pdwn1;
   logic              dcs0, dfs0, dcs1, dfs1;
   logic [NCH*OW-1:0] od0, od1;
   logic              ov0, ov1, run0, run1;
   logic [NCH*CW-1:0] oc0, oc1;

   int n_chk = 0;
   int n_bad = 0;
   int mcnt[NCH];

   always #5 clk = ~clk;

   adc_if_mc #(.DATA_W(DW), .NCH(NCH), .OUT_W(OW), .LOG2_AVG(0), .WAKE_CYC(WAKE),
               .PIPE_CYC(PIPE), .OTR_CNT_W(CW), .DCS_EN(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .fmt_twos(fmt_twos),
      .adc_data(adc_data), .adc_otr(adc_otr), .adc_oeb(oeb0), .adc_pdwn(pdwn0),
      .dcs(dcs0), .dfs(dfs0), .otr_clr(otr_clr), .out_data(od0), .out_valid(ov0),
      .otr_cnt(oc0), .running(run0));

   adc_if_mc #(.DATA_W(DW), .NCH(NCH), .OUT_W(OW), .LOG2_AVG(2), .WAKE_CYC(WAKE),
               .PIPE_CYC(PIPE), .OTR_CNT_W(CW), .DCS_EN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .fmt_twos(fmt_twos),
      .adc_data(adc_data), .adc_otr(adc_otr), .adc_oeb(oeb1), .adc_pdwn(pdwn1),
      .dcs(dcs1), .dfs(dfs1), .otr_clr(otr_clr), .out_data(od1), .out_valid(ov1),
      .otr_cnt(oc1), .running(run1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Numeric value of a pin word, then full-scale clamp when over range.
   function automatic int conv(input logic [DW-1:0] raw, input logic otr, input logic fmt);
      int v;
      if (fmt) v = (int'(raw) >= 2048) ? int'(raw) - 4096 : int'(raw);
      else     v = int'(raw) - 2048;
      if (otr) v = (v >= 0) ? 2047 : -2048;
      return v;
   endfunction

   // mode 0: directed offset-binary words then random with sparse OTR
   // mode 1: directed two's-complement words and averaging blocks
   // mode 2: OTR on every sample, counter clear with and without an event
   task automatic session(input logic [NCH-1:0] ch, input logic fmt,
                          input int last_k, input int mode);
      int cv[0:63][0:NCH-1];
      logic [NCH-1:0] nch;
      logic [NCH-1:0] ones;
      logic [DW-1:0]  d;
      logic [OW-1:0]  e;
      logic           o, clr, ev;
      int             s, b, sm;
      nch  = ~ch;
      ones = '1;
      @(negedge clk);
      en = 1'b1; ch_en = ch; fmt_twos = fmt; otr_clr = 1'b0;
      for (int k = 0; k <= last_k; k++) begin
         @(negedge clk);
         check("pdwn", pdwn0, nch);
         check("oeb", oeb0, (k >= WAKE) ? nch : ones);
         check("running", run0, k >= CAP0);
         check("running_avg", run1, k >= CAP0);
         check("dfs", dfs0, fmt);
         s = k - CAP0 - 3;
         check("valid", ov0, s >= 0);
         if (s >= 0)
            for (int c = 0; c < NCH; c++) begin
               e = ch[c] ? OW'(cv[s][c]) : '0;
               check($sformatf("data_ch%0d", c), od0[c*OW +: OW], e);
            end
         s = k - CAP0 - 6;
         check("valid_avg", ov1, (s >= 0) && (s % 4 == 0));
         if (s >= 0 && s % 4 == 0) begin
            b = s / 4;
            for (int c = 0; c < NCH; c++) begin
               sm = cv[4*b][c] + cv[4*b+1][c] + cv[4*b+2][c] + cv[4*b+3][c];
               e  = ch[c] ? OW'(sm >>> 2) : '0;
               check($sformatf("avg_ch%0d", c), od1[c*OW +: OW], e);
            end
         end
         for (int c = 0; c < NCH; c++) begin
            check($sformatf("otr_cnt_ch%0d", c), oc0[c*CW +: CW], mcnt[c]);
            check($sformatf("otr_cnt_avg_ch%0d", c), oc1[c*CW +: CW], mcnt[c]);
         end
         // inputs for edge k+1
         s = k + 1 - CAP0;
         ch_en    = NCH'($urandom);
         fmt_twos = 1'($urandom);
         clr = (mode == 2) && (s == -4 || s == 3);
         for (int c = 0; c < NCH; c++) begin
            d = DW'($urandom);
            o = ($urandom % 8) == 0;
            if (mode == 0 && s >= 0 && s < 3) begin
               d = (s == 0) ? 12'h800 : (s == 1) ? 12'hFFF : 12'h000;
               o = 1'b0;
            end
            if (mode == 1 && s >= 0 && s < 10) begin
               case (s)
                  0: d = 12'd100;  1: d = 12'd101;  2: d = 12'd102;  3: d = 12'd103;
                  4: d = 12'hFFF;  5: d = 12'hFFE;  6: d = 12'hFFE;  7: d = 12'hFFE;
                  8: d = 12'h800;  default: d = 12'h7FF;
               endcase
               o = 1'b0;
            end
            if (mode == 2) begin
               o = 1'b1;
               if (s >= 0 && s < 2) d = 12'hFFF;
            end
            adc_data[c*DW +: DW] = d;
            adc_otr[c] = o;
            if (k < last_k) begin
               if (s >= 0) cv[s][c] = conv(d, o, fmt);
               ev = (s >= 0) && ch[c] && o;
               if (clr)                        mcnt[c] = ev ? 1 : 0;
               else if (ev && mcnt[c] < CMAX)  mcnt[c] = mcnt[c] + 1;
            end
         end
         otr_clr = (k < last_k) ? clr : 1'b0;
         if (k == last_k) en = 1'b0;
      end
      @(negedge clk);
      check("off_pdwn", pdwn0, ones);
      check("off_oeb", oeb0, ones);
      check("off_valid", ov0, 0);
      check("off_valid_avg", ov1, 0);
      check("off_running", run0, 0);
      for (int c = 0; c < NCH; c++)
         check($sformatf("off_otr_cnt_ch%0d", c), oc0[c*CW +: CW], mcnt[c]);
   endtask

   initial begin
      for (int c = 0; c < NCH; c++) mcnt[c] = 0;
      #12;
      check("rst_pdwn", pdwn0, 2'b11);
      check("rst_oeb", oeb0, 2'b11);
      check("rst_dcs", dcs0, 1);
      check("rst_dfs", dfs0, 0);
      check("rst_data", od0, 0);
      check("rst_valid", ov0, 0);
      check("rst_otr_cnt", oc0, 0);
      check("rst_running", run0, 0);
      check("rst_valid_avg", ov1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      session(2'b11, 1'b0, CAP0 + 20, 0);
      session(2'b01, 1'b1, CAP0 + 16, 1);
      session(2'b11, 1'b0, CAP0 + 26, 2);
      session(2'b11, 1'b0, CAP0 + 1, 0);   // drop after 2 of a 4-sample block
      session(2'b10, 1'b1, CAP0 + 14, 0);  // re-enable: averages start fresh

      en = 1'b1; ch_en = 2'b11; fmt_twos = 1'b1;
      repeat (14) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_pdwn", pdwn0, 2'b11);
      check("arst_oeb", oeb0, 2'b11);
      check("arst_running", run0, 0);
      check("arst_valid", ov0, 0);
      check("arst_data", od0, 0);
      check("arst_otr_cnt", oc0, 0);
      check("arst_dfs", dfs0, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
